// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: sweeps one H_RES x V_RES frame out of a BRAM read
// port in raster order. Pixels are presented on a valid/ready stream with
// start-of-frame and end-of-line flags. A 2-entry FIFO hides the one-cycle
// BRAM read latency, so the block sustains one pixel per cycle under
// backpressure.
module frame_buffer_reader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int H_RES     = 32,
    parameter int V_RES     = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol
);

    localparam int CW = ADDR_W + 1;
    localparam int TOTAL = H_RES * V_RES;
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(H_RES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Issue-side raster position and count of reads issued so far
    logic [CW-1:0] x_p0, y_p0, issued_p0;

    // Read in flight: flags travel one cycle alongside the BRAM read
    logic vld_p1, sof_p1, eol_p1;

    // Output FIFO storage
    logic [DATA_W-1:0] fifo_data [2];
    logic              fifo_sof  [2];
    logic              fifo_eol  [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        fifo_cnt;

    logic       pop, push, issue, final_pop;
    logic [2:0] occ;

    // Occupancy after this edge, excluding any read issued now. The
    // handshake frees a slot in the same cycle, which keeps full rate.
    assign pop       = (fifo_cnt != 2'd0) && pix_ready;
    assign push      = vld_p1;
    assign occ       = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};
    assign issue     = (state == READ) && (occ < 3'd2);
    assign ram_en    = issue;
    // In DRAIN no more reads issue, so a lone head with nothing in flight
    // is the last pixel of the frame.
    assign final_pop = (state == DRAIN) && pop && (fifo_cnt == 2'd1) && !vld_p1;

    assign busy      = (state != IDLE);
    assign pix_valid = (fifo_cnt != 2'd0);
    assign pix_data  = fifo_data[rd_ptr];
    assign pix_sof   = fifo_sof[rd_ptr];
    assign pix_eol   = fifo_eol[rd_ptr];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (issue && (issued_p0 == LAST_IDX)) state_nxt = DRAIN;
            DRAIN:   if (final_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read address and raster counters; loaded at frame start, stepped per issued read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr  <= '0;
            x_p0      <= '0;
            y_p0      <= '0;
            issued_p0 <= '0;
        end else if ((state == IDLE) && start) begin
            ram_addr  <= ADDR_W'(BASE_ADDR);
            x_p0      <= '0;
            y_p0      <= '0;
            issued_p0 <= '0;
        end else if (issue) begin
            ram_addr  <= ram_addr + 1'b1;
            issued_p0 <= issued_p0 + 1'b1;
            if (x_p0 == X_LAST) begin
                x_p0 <= '0;
                y_p0 <= y_p0 + 1'b1;
            end else begin
                x_p0 <= x_p0 + 1'b1;
            end
        end
    end

    // ---- stage p0 -> p1: flags delayed to line up with ram_dout ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
            eol_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
            sof_p1 <= issue && (x_p0 == '0) && (y_p0 == '0);
            eol_p1 <= issue && (x_p0 == X_LAST);
        end
    end

    // ---- stage p1 -> FIFO: capture BRAM word with its flags ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_sof[0]  <= 1'b0;
            fifo_sof[1]  <= 1'b0;
            fifo_eol[0]  <= 1'b0;
            fifo_eol[1]  <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= ram_dout;
                fifo_sof[wr_ptr]  <= sof_p1;
                fifo_eol[wr_ptr]  <= eol_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // One-cycle completion pulse after the final handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= final_pop;
    end

endmodule
